// File: rtl/occupancy_pkg.sv
// Shared opcodes and parameter-legality helpers for the occupancy counter.
// The check macro expands to an elaboration-time generate block inside a module.
package occupancy_pkg;
  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'd0;
  localparam op_t OP_INC  = 3'd1;
  localparam op_t OP_DEC  = 3'd2;
  localparam op_t OP_LOAD = 3'd3;
  localparam op_t OP_CLR  = 3'd4;

  // WIDTH is capped so that 2^WIDTH-1 still fits a signed int parameter.
  function automatic bit params_legal(int w, int max_count, int af_thresh);
    return (w >= 1) && (w <= 30) &&
           (max_count >= 1) && (max_count <= ((1 << w) - 1)) &&
           (af_thresh >= 1) && (af_thresh <= max_count);
  endfunction
endpackage

`ifndef OCC_CHECK_PARAMS
`define OCC_CHECK_PARAMS(W, M, A) \
  if (!occupancy_pkg::params_legal(W, M, A)) begin : g_param_check \
    $error("occupancy_counter: illegal WIDTH/MAX_COUNT/AF_THRESH"); \
  end
`endif

// File: rtl/pulse_edge_detect.sv
// Qualifies a sensor input into an event: rising edge only, or level when EDGE_DETECT=0.
// History resets high so an input already asserted at reset release is ignored.
module pulse_edge_detect #(
  parameter int EDGE_DETECT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic ev_o
);
  logic hist_q, hist_d;

  always_comb hist_d = in_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= 1'b1;
    else          hist_q <= hist_d;
  end

  always_comb ev_o = (EDGE_DETECT != 0) ? (in_i & ~hist_q) : in_i;
endmodule

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter with clear/load, status decode and
// sticky overflow/underflow flags.
module occupancy_counter
  import occupancy_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MAX_COUNT   = 255,
  parameter int AF_THRESH   = 240,
  parameter int EDGE_DETECT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] val,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             ovf_err,
  output logic             unf_err
);
  `OCC_CHECK_PARAMS(WIDTH, MAX_COUNT, AF_THRESH)

  localparam logic [WIDTH-1:0] CAP = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] AF  = WIDTH'(AF_THRESH);

  // Lane 0 = inc, lane 1 = dec.
  logic [1:0] raw_ev, ev;
  assign raw_ev = {dec, inc};

  for (genvar i = 0; i < 2; i++) begin : g_evt
    pulse_edge_detect #(.EDGE_DETECT(EDGE_DETECT)) u_ped (
      .clk    (clk),
      .reset_n(reset_n),
      .in_i   (raw_ev[i]),
      .ev_o   (ev[i])
    );
  end

  op_t op;
  always_comb begin
    op = OP_HOLD;
    if      (clr)             op = OP_CLR;
    else if (load)            op = OP_LOAD;
    else if (ev[0] && !ev[1]) op = OP_INC;
    else if (ev[1] && !ev[0]) op = OP_DEC;
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_CLR:  cnt_d = '0;
      OP_LOAD: begin
        if (load_val > CAP) begin
          cnt_d   = CAP;
          ovf_set = 1'b1;
        end else begin
          cnt_d = load_val;
        end
      end
      OP_INC: begin
        if (cnt_q < CAP) cnt_d   = cnt_q + WIDTH'(1);
        else             ovf_set = 1'b1;
      end
      OP_DEC: begin
        if (cnt_q != '0) cnt_d   = cnt_q - WIDTH'(1);
        else             unf_set = 1'b1;
      end
      default: ;
    endcase
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_comb begin
    val         = cnt_q;
    full        = (cnt_q == CAP);
    empty       = (cnt_q == '0);
    almost_full = (cnt_q >= AF);
    ovf_err     = ovf_q;
    unf_err     = unf_q;
  end
endmodule

// File: tb/tb_occupancy_counter.sv
// Bench for occupancy_counter: one edge-qualified and one level-counting instance
// share stimulus; a behavioural model is checked every cycle plus literal checks.
module tb_occupancy_counter;
  localparam int W = 4, M = 10, A = 8;

  logic         clk = 1'b0, reset_n = 1'b0;
  logic         inc = 1'b0, dec = 1'b0, clr = 1'b0, load = 1'b0, err_clr = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] val  [2];
  logic         full [2], empty [2], af [2], ovf [2], unf [2];

  int tests = 0, fails = 0;

  occupancy_counter #(.WIDTH(W), .MAX_COUNT(M), .AF_THRESH(A), .EDGE_DETECT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .err_clr(err_clr), .val(val[0]), .full(full[0]),
    .empty(empty[0]), .almost_full(af[0]), .ovf_err(ovf[0]), .unf_err(unf[0]));

  occupancy_counter #(.WIDTH(W), .MAX_COUNT(M), .AF_THRESH(A), .EDGE_DETECT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .err_clr(err_clr), .val(val[1]), .full(full[1]),
    .empty(empty[1]), .almost_full(af[1]), .ovf_err(ovf[1]), .unf_err(unf[1]));

  always #5 clk = ~clk;

  // Behavioural model; index 0 = level counting, 1 = rising-edge counting.
  int m_val [2];
  bit m_ovf [2], m_unf [2], m_pi [2], m_pd [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_val[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_pi[k] = 1; m_pd[k] = 1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit ie, de, so, su;
        ie = (k == 1) ? (inc && !m_pi[k]) : inc;
        de = (k == 1) ? (dec && !m_pd[k]) : dec;
        m_pi[k] = inc;
        m_pd[k] = dec;
        so = 0; su = 0;
        if (clr) m_val[k] = 0;
        else if (load) begin
          if (int'(load_val) > M) begin m_val[k] = M; so = 1; end
          else m_val[k] = int'(load_val);
        end else if (ie && de) ;
        else if (ie) begin
          if (m_val[k] < M) m_val[k]++; else so = 1;
        end else if (de) begin
          if (m_val[k] > 0) m_val[k]--; else su = 1;
        end
        m_ovf[k] = so || (m_ovf[k] && !err_clr);
        m_unf[k] = su || (m_unf[k] && !err_clr);
      end
    end
  end

  // Continuous compare of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (int'(val[k]) != m_val[k] || full[k] != (m_val[k] == M) ||
          empty[k] != (m_val[k] == 0) || af[k] != (m_val[k] >= A) ||
          ovf[k] != m_ovf[k] || unf[k] != m_unf[k]) begin
        fails++;
        $display("FAIL model_cmp dut%0d t=%0t got val=%0d f=%b e=%b af=%b o=%b u=%b exp val=%0d o=%b u=%b",
                 k, $time, val[k], full[k], empty[k], af[k], ovf[k], unf[k],
                 m_val[k], m_ovf[k], m_unf[k]);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic i, input logic d);
    inc = i; dec = d; tick();
    inc = 0; dec = 0; tick();
  endtask

  task automatic do_load(input int v);
    load = 1; load_val = W'(v); tick();
    load = 0;
  endtask

  initial begin
    inc = 1;
    tick(); tick();
    reset_n = 1;
    chk("rst_val", val[1], 0);   chk("rst_empty", empty[1], 1);
    chk("rst_full", full[1], 0); chk("rst_af", af[1], 0);
    chk("rst_ovf", ovf[1], 0);   chk("rst_unf", unf[1], 0);
    repeat (5) tick();
    chk("held_inc_val", val[1], 0); chk("held_inc_empty", empty[1], 1);
    chk("held_inc_lvl_val", val[0], 5);
    inc = 0; tick();
    for (int i = 1; i <= 3; i++) begin
      pulse(1, 0);
      chk("pulse_val", val[1], i);
    end
    for (int i = 4; i <= 10; i++) begin
      pulse(1, 0);
      if (i == 7)  chk("af_below", af[1], 0);
      if (i == 8)  chk("af_at_thresh", af[1], 1);
      if (i == 9)  chk("full_below", full[1], 0);
      if (i == 10) chk("full_at_max", full[1], 1);
    end
    pulse(1, 0);
    chk("sat_val", val[1], 10); chk("sat_ovf", ovf[1], 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("errclr_ovf", ovf[1], 0);

    clr = 1; tick(); clr = 0;
    pulse(0, 1);
    chk("unf_val", val[1], 0); chk("unf_flag", unf[1], 1);
    err_clr = 1; tick(); err_clr = 0;
    do_load(10); tick();
    pulse(1, 1);
    chk("both_val", val[1], 10); chk("both_ovf", ovf[1], 0); chk("both_unf", unf[1], 0);

    do_load(13);
    chk("load13_val", val[1], 10); chk("load13_ovf", ovf[1], 1); chk("load13_full", full[1], 1);
    err_clr = 1; tick(); err_clr = 0;
    load = 1; load_val = 4; inc = 1; tick();
    load = 0; inc = 0; tick();
    chk("load_inc_val", val[1], 4);

    do_load(6); chk("load6_val", val[1], 6);
    clr = 1; load = 1; load_val = 9; inc = 1; tick();
    clr = 0; load = 0; inc = 0;
    chk("clr_prio_val", val[1], 0);
    tick();
    inc = 1; repeat (4) tick(); inc = 0;
    chk("level_hold_val", val[0], 4); chk("edge_hold_val", val[1], 1);

    do_load(7); tick();
    chk("pre_rst_val", val[1], 7);
    #2 reset_n = 0;
    #1;
    chk("async_rst_val", val[1], 0); chk("async_rst_empty", empty[1], 1);
    chk("async_rst_af", af[1], 0);
    tick(); reset_n = 1; tick();

    do_load(10); tick();
    pulse(1, 0);
    chk("full_inc_ovf", ovf[1], 1);
    inc = 1; err_clr = 1; tick(); inc = 0; err_clr = 0;
    chk("set_beats_clr", ovf[1], 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("final_clr_ovf", ovf[1], 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
Parametrised up/down occupancy counter, the next generation of the car-park counter.
- Counts entry/exit sensor events against a configurable capacity, with optional rising-edge qualification of the sensor inputs.
- Provides synchronous clear and load, and status flags: full, empty, almost-full.
- Provides sticky overflow/underflow error flags.
- Sits between the sensor debouncers and the display/gate-control logic.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_COUNT, 255, capacity; legal range 1..2^WIDTH-1, checked at elaboration.
- AF_THRESH, 240, almost_full asserts when val >= AF_THRESH; legal range 1..MAX_COUNT.
- EDGE_DETECT, 1, 1 = count one event per rising edge of inc/dec; 0 = count every cycle the input is high.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- inc  in  1  entry event.
- dec  in  1  exit event.
- clr  in  1  synchronous clear of the count.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- err_clr  in  1  clears the sticky error flags.
- val  out  WIDTH  current count.
- full  out  1  val == MAX_COUNT.
- empty  out  1  val == 0.
- almost_full  out  1  val >= AF_THRESH.
- ovf_err  out  1  sticky; increment attempted at full, or load_val > MAX_COUNT.
- unf_err  out  1  sticky; decrement attempted at empty.

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n); the clock port is clk.
- Reset (reset_n=0), immediate and asynchronous:
  - val=0, empty=1, full=0, almost_full=0, ovf_err=0, unf_err=0.
  - Edge-detect history registers are reset to 1, so an input already high at reset release is not counted.
- Event qualification:
  - EDGE_DETECT=1: inc_ev = inc & ~inc_q, where inc_q is inc registered; dec likewise.
  - EDGE_DETECT=0: inc_ev = inc, dec_ev = dec.
- Latency: an event sampled at clock edge n updates val at edge n. val is visible one cycle after the input is presented; there is no extra pipeline stage.
- Priority per cycle, highest first:
  - clr: val=0; no error flags change.
  - load: val = min(load_val, MAX_COUNT); ovf_err set if load_val > MAX_COUNT. Events in the same cycle are discarded; edge history still updates.
  - inc_ev & dec_ev together: net zero, val holds, no error, even at full or empty.
  - inc_ev only: if val < MAX_COUNT then val+1, else val holds and ovf_err is set.
  - dec_ev only: if val > 0 then val-1, else val holds and unf_err is set.
  - no event: val holds.
- val never wraps, in either direction.
- Flags full, empty, almost_full are decoded combinationally from the count register, so they are cycle-aligned with val.
- err_clr clears both sticky flags at the next edge. If an error event occurs in the same cycle, set wins over clear.
- Reset asserted mid-operation aborts any pending load or event; there is no partial update.

Decomposition:
- Shared package/header occupancy_pkg holds:
  - localparam opcodes OP_HOLD, OP_INC, OP_DEC, OP_LOAD, OP_CLR, used by the next-state selector and the bench scoreboard.
  - the parameter-legality check macro.
- One natural sub-module: pulse_edge_detect, parameter EDGE_DETECT. It has its own history register (reset to 1) and outputs a qualified one-cycle event. It is instantiated twice, for inc and dec.
- The top level holds the state register, the next-state logic and the flag decode.

Test Plan:
All scenarios use WIDTH=4, MAX_COUNT=10, AF_THRESH=8, EDGE_DETECT=1 unless stated otherwise.
- Reset release with inc held high for 5 cycles -> val stays 0, empty=1. Then drop inc and give three 1-cycle inc pulses -> val=3, one cycle after each pulse.
- Count up to 10 -> almost_full rises at val=8 and full at val=10. One more inc pulse -> val stays 10 and ovf_err=1. err_clr -> ovf_err=0 next cycle.
- At val=0, dec pulse -> val=0, unf_err=1. At val=10, assert inc and dec rising together -> val=10 with no error.
- load=1, load_val=13 -> val=10, ovf_err=1, full=1. load with load_val=4 plus a simultaneous inc edge -> val=4 (the inc is discarded).
- At val=6, assert clr, load and inc in the same cycle -> val=0. With EDGE_DETECT=0, hold inc for 4 cycles -> val=4.
- At val=7, assert reset_n=0 asynchronously mid-cycle -> val=0 and flags at reset values before the next clk edge. Inc event in the same cycle as err_clr at full -> ovf_err stays 1.
